// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: byte-serial RV32I data-memory responder.
// Ports: req_valid/req_ready in, mem_read/mem_write/addr/wdata; rsp_valid/rdata/rsp_err out.
module data_mem_ctrl #(
  parameter int ADDR_W = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  mem_read,
  input  logic [1:0]  mem_write,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        rsp_valid,
  output logic [31:0] rdata,
  output logic        rsp_err
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t              state_q;
  logic [1:0]          cnt_q;
  logic [1:0]          last_q;
  logic                st_q;
  logic                sgn_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         buf_q;
  logic                rsp_valid_q;
  logic [31:0]         rdata_q;
  logic                rsp_err_q;

  logic [7:0]          mem_q [2**ADDR_W];

  logic                is_rd;
  logic                is_wr;
  logic                is_req;
  logic [1:0]          size_d;
  logic                rsvd_d;
  logic                misal_d;
  logic                err_d;
  logic [1:0]          last_d;

  logic [ADDR_W-1:0]   ram_a;
  logic [7:0]          rd_byte;
  logic                ram_we;
  logic [31:0]         word_d;
  logic [31:0]         ext_d;
  logic                done;

  logic                unused_addr;

  assign unused_addr = ^addr[31:ADDR_W];

  // Size code: 01 byte, 10 half, 11 word (same for reads and writes).
  always_comb begin
    is_rd   = |mem_read;
    is_wr   = |mem_write;
    is_req  = is_rd | is_wr;
    size_d  = is_rd ? mem_read[1:0] : mem_write;
    rsvd_d  = (mem_read == 3'b011) | (mem_read == 3'b100);
    misal_d = ((size_d == 2'b10) & addr[0]) |
              ((size_d == 2'b11) & (|addr[1:0]));
    err_d   = rsvd_d | (is_rd & is_wr) | misal_d;
    last_d  = 2'd0;
    unique case (1'b1)
      size_d == 2'b11: last_d = 2'd3;
      size_d == 2'b10: last_d = 2'd1;
      default:         last_d = 2'd0;
    endcase
  end

  assign ram_a   = addr_q + ADDR_W'(cnt_q);
  assign rd_byte = mem_q[ram_a];
  assign ram_we  = (state_q == ACCESS) & st_q;
  assign done    = cnt_q == last_q;

  // Merge the byte read this cycle so the final byte reaches rdata
  // in the same edge that enters RESP.
  always_comb begin
    word_d = buf_q;
    word_d[8*cnt_q +: 8] = rd_byte;
  end

  always_comb begin
    ext_d = word_d;
    unique case (1'b1)
      last_q == 2'd0:
        ext_d = sgn_q ? {{24{word_d[7]}}, word_d[7:0]}
                      : {24'b0, word_d[7:0]};
      last_q == 2'd1:
        ext_d = sgn_q ? {{16{word_d[15]}}, word_d[15:0]}
                      : {16'b0, word_d[15:0]};
      default:
        ext_d = word_d;
    endcase
  end

  // RAM contents survive reset, so it sits outside the reset domain.
  always_ff @(posedge clk) begin
    if (ram_we) begin
      mem_q[ram_a] <= wdata_q[8*cnt_q +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      cnt_q       <= 2'd0;
      last_q      <= 2'd0;
      st_q        <= 1'b0;
      sgn_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= 32'd0;
      buf_q       <= 32'd0;
      rsp_valid_q <= 1'b0;
      rdata_q     <= 32'd0;
      rsp_err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          rsp_valid_q <= 1'b0;
          if (req_valid && is_req) begin
            cnt_q   <= 2'd0;
            buf_q   <= 32'd0;
            last_q  <= last_d;
            st_q    <= is_wr & ~is_rd;
            sgn_q   <= mem_read[2];
            addr_q  <= addr[ADDR_W-1:0];
            wdata_q <= wdata;
            if (err_d) begin
              state_q     <= RESP;
              rsp_valid_q <= 1'b1;
              rsp_err_q   <= 1'b1;
              rdata_q     <= 32'd0;
            end else begin
              state_q <= ACCESS;
            end
          end
        end
        ACCESS: begin
          if (!st_q) begin
            buf_q <= word_d;
          end
          if (done) begin
            state_q     <= RESP;
            rsp_valid_q <= 1'b1;
            rsp_err_q   <= 1'b0;
            rdata_q     <= st_q ? 32'd0 : ext_d;
          end else begin
            cnt_q <= cnt_q + 2'd1;
          end
        end
        RESP: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
        default: begin
          rsp_valid_q <= 1'b0;
          state_q     <= IDLE;
        end
      endcase
    end
  end

  assign req_ready = rst & (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rdata     = rdata_q;
  assign rsp_err   = rsp_err_q;

endmodule
